// File: rtl/reset_seq_ctrl.sv
// Multi-channel reset sequencer: a masked trigger edge pulses each active-low channel reset in index
// order, separated by a common gap. Define RST_SEQ_RETRIGGER_EN to let an event restart a running sequence.
module reset_seq_ctrl #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned NUM_TRIG = 2,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned EVT_W    = 8
) (
    input  logic                    clk,
    input  logic                    sys_res,
    input  logic [NUM_TRIG-1:0]     trig,
    input  logic [NUM_TRIG-1:0]     trig_mask,
    input  logic [NUM_CH*CNT_W-1:0] assert_len,
    input  logic [CNT_W-1:0]        gap_len,
    input  logic                    cause_clr,
    output logic [NUM_CH-1:0]       ch_res_n,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_TRIG-1:0]     cause,
    output logic [EVT_W-1:0]        evt_cnt
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {StIdle, StAssert, StGap} state_e;

    state_e                  state;
    logic [IDX_W-1:0]        idx;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_CH*CNT_W-1:0] len_sh;
    logic [CNT_W-1:0]        gap_sh;
    logic [NUM_TRIG-1:0]     trig_q;

    logic [NUM_TRIG-1:0]     trig_edge;
    logic                    ev;
    logic                    start;
    logic                    last_ch;
    logic                    gap_zero;
    logic [CNT_W-1:0]        cur_len;
    logic [CNT_W-1:0]        cur_end;
    logic [CNT_W-1:0]        gap_end;
    logic [IDX_W-1:0]        nxt_idx;
    logic [NUM_CH-1:0]       nxt_low_n;

    assign trig_edge = trig & ~trig_q & trig_mask;
    assign ev        = |trig_edge;

`ifdef RST_SEQ_RETRIGGER_EN
    assign start = ev;
`else
    assign start = ev && (state == StIdle);
`endif

    assign nxt_idx  = idx + IDX_W'(1);
    assign last_ch  = (idx == IDX_W'(NUM_CH - 1));
    assign gap_zero = (gap_sh == '0);
    // A zero length behaves as one cycle, so the terminal count saturates at 0.
    assign cur_end  = (cur_len == '0) ? '0 : cur_len - CNT_W'(1);
    assign gap_end  = gap_sh - CNT_W'(1);

    always_comb begin
        cur_len   = '0;
        nxt_low_n = '1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_len = len_sh[k*CNT_W +: CNT_W];
            end
            if (nxt_idx == IDX_W'(k)) begin
                nxt_low_n[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sys_res) begin
            state    <= StIdle;
            idx      <= '0;
            cnt      <= '0;
            len_sh   <= '0;
            gap_sh   <= '0;
            trig_q   <= '1;
            ch_res_n <= '1;
            busy     <= 1'b0;
            done     <= 1'b0;
            cause    <= '0;
            evt_cnt  <= '0;
        end else begin
            trig_q <= trig;
            cause  <= (cause_clr ? '0 : cause) | trig_edge;
            done   <= 1'b0;
            if (start) begin
                // Restart also releases whichever channel was low, except ch0 which stays low.
                state       <= StAssert;
                idx         <= '0;
                cnt         <= '0;
                len_sh      <= assert_len;
                gap_sh      <= gap_len;
                busy        <= 1'b1;
                ch_res_n    <= '1;
                ch_res_n[0] <= 1'b0;
                if (evt_cnt != '1) begin
                    evt_cnt <= evt_cnt + EVT_W'(1);
                end
            end else begin
                case (state)
                    StAssert: begin
                        if (cnt == cur_end) begin
                            cnt <= '0;
                            if (!gap_zero) begin
                                state    <= StGap;
                                ch_res_n <= '1;
                            end else if (last_ch) begin
                                state    <= StIdle;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                ch_res_n <= '1;
                            end else begin
                                idx      <= nxt_idx;
                                ch_res_n <= nxt_low_n;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    StGap: begin
                        if (cnt == gap_end) begin
                            cnt <= '0;
                            if (last_ch) begin
                                state <= StIdle;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state    <= StAssert;
                                idx      <= nxt_idx;
                                ch_res_n <= nxt_low_n;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Scoreboard bench for reset_seq_ctrl: stimulus queues the expected per-sequence timeline, the
// monitor measures channel low windows and compares them when done pulses.
module tb_reset_seq_ctrl;

    logic        clk = 1'b0;
    logic        sys_res;
    logic [1:0]  trig;
    logic [1:0]  trig_mask;
    logic [15:0] assert_len;
    logic [7:0]  gap_len;
    logic        cause_clr;
    logic [1:0]  ch_res_n;
    logic        busy;
    logic        done;
    logic [1:0]  cause;
    logic [7:0]  evt_cnt;

    typedef struct {
        int c0s;
        int c0e;
        int c1s;
        int c1e;
        int dn;
        int evt;
        int cs;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_evt = 0;
    int   t0;
    int   first_lo[2] = '{-1, -1};
    int   last_lo[2] = '{-1, -1};

    reset_seq_ctrl dut (
        .clk       (clk),
        .sys_res   (sys_res),
        .trig      (trig),
        .trig_mask (trig_mask),
        .assert_len(assert_len),
        .gap_len   (gap_len),
        .cause_clr (cause_clr),
        .ch_res_n  (ch_res_n),
        .busy      (busy),
        .done      (done),
        .cause     (cause),
        .evt_cnt   (evt_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bump();
        if (exp_evt < 255) exp_evt++;
    endtask

    task automatic push(input int t, input int a, input int b, input int c, input int d,
                        input int e, input int evt, input int cs);
        exp_t x;
        x.c0s = t + a;
        x.c0e = t + b;
        x.c1s = t + c;
        x.c1e = t + d;
        x.dn  = t + e;
        x.evt = evt;
        x.cs  = cs;
        exp_q.push_back(x);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < max_cyc) begin
            tick(1);
            n++;
        end
        chk("drain_idle", (exp_q.size() == 0) && (busy === 1'b0), 1);
    endtask

    // Monitor: measures low windows per sequence and checks them against the queue on done.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("one_low", $countones(~ch_res_n) <= 1, 1);
            for (int k = 0; k < 2; k++) begin
                if (ch_res_n[k] === 1'b0) begin
                    if (first_lo[k] < 0) first_lo[k] = cyc;
                    last_lo[k] = cyc;
                end
            end
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, expected done=0", cyc);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk("ch0_low_start", first_lo[0], x.c0s);
                    chk("ch0_low_end", last_lo[0], x.c0e);
                    chk("ch1_low_start", first_lo[1], x.c1s);
                    chk("ch1_low_end", last_lo[1], x.c1e);
                    chk("done_cycle", cyc, x.dn);
                    chk("evt_cnt_at_done", evt_cnt, x.evt);
                    chk("cause_at_done", cause, x.cs);
                end
                first_lo = '{-1, -1};
                last_lo  = '{-1, -1};
            end else if (busy === 1'b0) begin
                first_lo = '{-1, -1};
                last_lo  = '{-1, -1};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        sys_res    = 1'b1;
        trig       = 2'b01;
        trig_mask  = 2'b11;
        assert_len = {8'd3, 8'd60};
        gap_len    = 8'd5;
        cause_clr  = 1'b0;
        tick(3);
        chk("rst_ch_res_n", ch_res_n, 2'b11);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cause", cause, 0);
        chk("rst_evt_cnt", evt_cnt, 0);

        // Trigger held high across reset release must not fire.
        sys_res = 1'b0;
        tick(20);
        chk("held_busy", busy, 0);
        chk("held_evt_cnt", evt_cnt, 0);
        chk("held_cause", cause, 0);
        trig = 2'b00;
        tick(2);

        // Masked source: no sequence, no cause.
        trig_mask = 2'b10;
        trig[0]   = 1'b1;
        tick(10);
        chk("masked_busy", busy, 0);
        chk("masked_cause", cause, 0);
        chk("masked_evt_cnt", evt_cnt, 0);
        trig      = 2'b00;
        trig_mask = 2'b11;
        tick(2);

        // Reference sequence; lengths changed mid-run must not matter.
        t0      = cyc;
        trig[0] = 1'b1;
        bump();
        push(t0, 1, 60, 66, 68, 74, exp_evt, 1);
        tick(5);
        assert_len = {8'd9, 8'd1};
        gap_len    = 8'd1;
        trig       = 2'b00;
        drain(200);

        // Zero ch0 length and zero gap.
        assert_len = {8'd2, 8'd0};
        gap_len    = 8'd0;
        tick(1);
        t0      = cyc;
        trig[0] = 1'b1;
        bump();
        push(t0, 1, 1, 2, 3, 4, exp_evt, 1);
        tick(1);
        trig = 2'b00;
        drain(50);

        // trig[1] edge mid-sequence.
        assert_len = {8'd3, 8'd60};
        gap_len    = 8'd5;
        tick(1);
        t0      = cyc;
        trig[0] = 1'b1;
        bump();
`ifdef RST_SEQ_RETRIGGER_EN
        bump();
        push(t0, 1, 80, 86, 88, 94, exp_evt, 3);
`else
        push(t0, 1, 60, 66, 68, 74, exp_evt, 3);
`endif
        tick(20);
        trig[1] = 1'b1;
        tick(2);
        trig = 2'b00;
        drain(300);

        // cause_clr and a new edge in the same cycle: the set wins.
        assert_len = {8'd0, 8'd0};
        gap_len    = 8'd0;
        tick(1);
        t0        = cyc;
        trig[0]   = 1'b1;
        cause_clr = 1'b1;
        bump();
        push(t0, 1, 1, 2, 2, 3, exp_evt, 1);
        tick(1);
        chk("clr_vs_set_cause", cause, 2'b01);
        cause_clr = 1'b0;
        trig      = 2'b00;
        drain(50);

        // Maximum length: no counter wrap.
        assert_len = {8'd1, 8'd255};
        gap_len    = 8'd0;
        tick(1);
        t0      = cyc;
        trig[0] = 1'b1;
        bump();
        push(t0, 1, 255, 256, 256, 257, exp_evt, 1);
        tick(1);
        trig = 2'b00;
        drain(400);

        // Event counter saturation.
        assert_len = {8'd0, 8'd0};
        gap_len    = 8'd0;
        tick(1);
        for (int i = 0; i < 300; i++) begin
            t0      = cyc;
            trig[0] = 1'b1;
            bump();
            push(t0, 1, 1, 2, 2, 3, exp_evt, 1);
            tick(1);
            trig[0] = 1'b0;
            tick(3);
        end
        drain(50);
        chk("evt_saturated", evt_cnt, 255);

        // sys_res during ASSERT(1) aborts without a done pulse.
        assert_len = {8'd10, 8'd2};
        gap_len    = 8'd2;
        tick(1);
        t0      = cyc;
        trig[0] = 1'b1;
        tick(1);
        trig[0] = 1'b0;
        tick(7);
        chk("abort_in_assert1", ch_res_n, 2'b01);
        sys_res = 1'b1;
        tick(1);
        chk("abort_ch_res_n", ch_res_n, 2'b11);
        chk("abort_busy", busy, 0);
        chk("abort_cause", cause, 0);
        chk("abort_done", done, 0);
        chk("abort_evt_cnt", evt_cnt, 0);
        sys_res = 1'b0;
        tick(30);
        chk("abort_no_resume", busy, 0);
        chk("abort_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
